// File: rtl/mc_bus_responder.sv
// MCU parallel-bus responder: synchronizes the asynchronous MCU strobes, address and
// data into the clock domain, turns each MCU write into a one-cycle reg_wr and each
// MCU read into a reg_rd request whose returned data is driven back while the read lasts.
module mc_bus_responder #(
    parameter int unsigned MC_DATA_WIDTH = 16,
    parameter int unsigned MC_ADD_WIDTH = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_TIMEOUT = 8,
    parameter logic [MC_DATA_WIDTH-1:0] TIMEOUT_DATA = 16'hDEAD
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mc_ce,
    input  logic                     mc_we,
    input  logic                     mc_oe,
    input  logic [MC_ADD_WIDTH-1:0]  mc_add,
    input  logic [MC_DATA_WIDTH-1:0] mc_data_in,
    output logic [MC_DATA_WIDTH-1:0] mc_data_out,
    output logic                     mc_data_oe,
    output logic                     reg_wr,
    output logic                     reg_rd,
    output logic [MC_ADD_WIDTH-1:0]  reg_addr,
    output logic [MC_DATA_WIDTH-1:0] reg_wdata,
    input  logic [MC_DATA_WIDTH-1:0] reg_rdata,
    input  logic                     reg_rvalid,
    output logic                     bus_err,
    output logic [7:0]               err_count
);

    localparam int unsigned TW = $clog2(RD_TIMEOUT) + 1;
    localparam logic [TW-1:0] TmoLast = TW'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWrHold, StRdWait, StRdDrive} state_e;

    // Synchronizers: bit 0 is the first stage, the top bit is the synchronized value
    logic [SYNC_STAGES-1:0]   ce_sync_q, we_sync_q, oe_sync_q;
    logic [MC_ADD_WIDTH-1:0]  add_pipe_q  [SYNC_STAGES];
    logic [MC_DATA_WIDTH-1:0] data_pipe_q [SYNC_STAGES];
    logic                     we_prev_q, oe_prev_q;
    logic                     ce_s, we_s, oe_s;
    logic                     we_fall, oe_fall, wr_start, rd_start;

    state_e                   state_q, state_d;
    logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
    logic                     reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;
    logic [MC_ADD_WIDTH-1:0]  reg_addr_q, reg_addr_d;
    logic [MC_DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
    logic [MC_DATA_WIDTH-1:0] hold_q, hold_d;
    logic                     data_oe_q, data_oe_d;
    logic                     bus_err_q, bus_err_d;
    logic [7:0]               err_count_q, err_count_d;

    assign ce_s = ce_sync_q[SYNC_STAGES-1];
    assign we_s = we_sync_q[SYNC_STAGES-1];
    assign oe_s = oe_sync_q[SYNC_STAGES-1];

    assign we_fall  = we_prev_q & ~we_s;
    assign oe_fall  = oe_prev_q & ~oe_s;
    assign wr_start = we_fall & ~ce_s & oe_s;
    assign rd_start = oe_fall & ~ce_s & we_s;

    // Strobe synchronizers, equal-depth address/data pipelines and edge-detect history
    always_ff @(posedge clock) begin
        if (reset) begin
            ce_sync_q <= '1;
            we_sync_q <= '1;
            oe_sync_q <= '1;
            we_prev_q <= 1'b1;
            oe_prev_q <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                add_pipe_q[i]  <= '0;
                data_pipe_q[i] <= '0;
            end
        end else begin
            ce_sync_q      <= {ce_sync_q[SYNC_STAGES-2:0], mc_ce};
            we_sync_q      <= {we_sync_q[SYNC_STAGES-2:0], mc_we};
            oe_sync_q      <= {oe_sync_q[SYNC_STAGES-2:0], mc_oe};
            we_prev_q      <= we_s;
            oe_prev_q      <= oe_s;
            add_pipe_q[0]  <= mc_add;
            data_pipe_q[0] <= mc_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                add_pipe_q[i]  <= add_pipe_q[i-1];
                data_pipe_q[i] <= data_pipe_q[i-1];
            end
        end
    end

    // Next-state and next-output logic for the access FSM
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        hold_d      = hold_q;
        bus_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr_start) begin
                    reg_wr_d    = 1'b1;
                    reg_addr_d  = add_pipe_q[SYNC_STAGES-1];
                    reg_wdata_d = data_pipe_q[SYNC_STAGES-1];
                    state_d     = StWrHold;
                end else if (rd_start) begin
                    reg_rd_d   = 1'b1;
                    reg_addr_d = add_pipe_q[SYNC_STAGES-1];
                    tmo_cnt_d  = '0;
                    state_d    = StRdWait;
                end else if (we_fall || oe_fall) begin
                    // Strobe fell with chip deselected, or both strobes active
                    bus_err_d = 1'b1;
                end
            end
            StWrHold: begin
                if (we_s || ce_s) state_d = StIdle;
            end
            StRdWait: begin
                // An MCU abort wins; a late reg_rvalid is then ignored in IDLE
                if (oe_s || ce_s) begin
                    state_d = StIdle;
                end else if (reg_rvalid) begin
                    hold_d  = reg_rdata;
                    state_d = StRdDrive;
                end else if (tmo_cnt_q == TmoLast) begin
                    hold_d    = TIMEOUT_DATA;
                    bus_err_d = 1'b1;
                    state_d   = StRdDrive;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StRdDrive: begin
                if (oe_s || ce_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        data_oe_d   = (state_d == StRdDrive);
        err_count_d = (bus_err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            tmo_cnt_q   <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            hold_q      <= '0;
            data_oe_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            hold_q      <= hold_d;
            data_oe_q   <= data_oe_d;
            bus_err_q   <= bus_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign mc_data_out = hold_q;
    assign mc_data_oe  = data_oe_q;
    assign reg_wr      = reg_wr_q;
    assign reg_rd      = reg_rd_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign bus_err     = bus_err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_mc_bus_responder.sv
// Directed bench for mc_bus_responder: writes, reads, timeout, abort, error counting,
// reset in the middle of a read. Inputs change 1 time unit after the rising edge and
// outputs are sampled there too, so iteration i sees the state after edge i.
module tb_mc_bus_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mc_ce = 1'b1, mc_we = 1'b1, mc_oe = 1'b1;
    logic [5:0]  mc_add = '0;
    logic [15:0] mc_data_in = '0;
    logic [15:0] mc_data_out;
    logic        mc_data_oe, reg_wr, reg_rd, bus_err;
    logic [5:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = '0;
    logic        reg_rvalid = 1'b0;
    logic [7:0]  err_count;

    int total = 0;
    int bad = 0;

    mc_bus_responder dut (
        .clock       (clock),
        .reset       (reset),
        .mc_ce       (mc_ce),
        .mc_we       (mc_we),
        .mc_oe       (mc_oe),
        .mc_add      (mc_add),
        .mc_data_in  (mc_data_in),
        .mc_data_out (mc_data_out),
        .mc_data_oe  (mc_data_oe),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .bus_err     (bus_err),
        .err_count   (err_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1; reg_rvalid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // One MCU write; 'sel' drives mc_ce low with the strobe
    task automatic do_write(input logic [5:0] a, input logic [15:0] d, input logic sel,
                            input int pre, input int low, input int len,
                            output int cnt, output int at, output logic [5:0] ra,
                            output logic [15:0] rd, output int errs, output int oe_any);
        cnt = 0; at = 0; ra = '0; rd = '0; errs = 0; oe_any = 0;
        mc_add = a; mc_data_in = d;
        for (int i = 0; i < pre; i++) step();
        mc_ce = ~sel; mc_we = 1'b0;
        for (int i = 1; i <= len; i++) begin
            step();
            if (reg_wr) begin cnt++; at = i; ra = reg_addr; rd = reg_wdata; end
            if (bus_err) errs++;
            if (mc_data_oe) oe_any++;
            if (i == low) begin mc_we = 1'b1; mc_ce = 1'b1; end
        end
    endtask

    // One MCU read; register file answers with a 1-cycle reg_rvalid after iteration rv_at
    task automatic do_read(input logic [5:0] a, input logic [15:0] rdata, input int low,
                           input int rv_at, input int len,
                           output int rd_cnt, output int rd_at, output logic [5:0] ra,
                           output int rise_at, output int fall_at,
                           output logic [15:0] dat, output int errs);
        rd_cnt = 0; rd_at = 0; ra = '0; rise_at = 0; fall_at = 0; dat = '0; errs = 0;
        mc_add = a;
        for (int i = 0; i < 4; i++) step();
        mc_ce = 1'b0; mc_oe = 1'b0;
        for (int i = 1; i <= len; i++) begin
            step();
            if (reg_rd) begin rd_cnt++; rd_at = i; ra = reg_addr; end
            if (bus_err) errs++;
            if (mc_data_oe && rise_at == 0) begin rise_at = i; dat = mc_data_out; end
            if (!mc_data_oe && rise_at != 0 && fall_at == 0) fall_at = i;
            if (i == low) begin mc_oe = 1'b1; mc_ce = 1'b1; end
            reg_rvalid = (i == rv_at);
            reg_rdata  = (i == rv_at) ? rdata : 16'h0000;
        end
        reg_rvalid = 1'b0;
    endtask

    // Both strobes low together; counts error pulses and any register access
    task automatic do_both(input int low, input int high, output int errs, output int acc);
        errs = 0; acc = 0;
        mc_ce = 1'b0; mc_we = 1'b0; mc_oe = 1'b0;
        for (int i = 1; i <= low + high; i++) begin
            step();
            if (bus_err) errs++;
            if (reg_wr || reg_rd) acc++;
            if (i == low) begin mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1; end
        end
    endtask

    initial begin
        int cnt, at, errs, oe_any, rd_cnt, rise, fall, acc;
        logic [5:0] ra;
        logic [15:0] rdv;

        // Reset state (sampled while reset is still high)
        step();
        check("rst_data_out", 32'(mc_data_out), 32'h0);
        check("rst_data_oe", 32'(mc_data_oe), 32'h0);
        check("rst_reg_wr", 32'(reg_wr), 32'h0);
        check("rst_reg_rd", 32'(reg_rd), 32'h0);
        check("rst_reg_addr", 32'(reg_addr), 32'h0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_err_count", 32'(err_count), 32'h0);
        do_reset();

        // Single write
        do_write(6'h19, 16'h0001, 1'b1, 4, 6, 12, cnt, at, ra, rdv, errs, oe_any);
        check("wr_count", 32'(cnt), 32'd1);
        check("wr_latency", 32'(at), 32'd3);
        check("wr_addr", 32'(ra), 32'h19);
        check("wr_data", 32'(rdv), 32'h0001);
        check("wr_no_oe", 32'(oe_any), 32'd0);
        check("wr_no_err", 32'(errs), 32'd0);

        // Back-to-back writes, 6 high cycles between strobes
        do_write(6'h04, 16'h0010, 1'b1, 4, 6, 9, cnt, at, ra, rdv, errs, oe_any);
        check("b2b1_count", 32'(cnt), 32'd1);
        check("b2b1_pair", {10'h0, ra, rdv}, {10'h0, 6'h04, 16'h0010});
        do_write(6'h02, 16'h0001, 1'b1, 3, 6, 12, cnt, at, ra, rdv, errs, oe_any);
        check("b2b2_count", 32'(cnt), 32'd1);
        check("b2b2_latency", 32'(at), 32'd3);
        check("b2b2_pair", {10'h0, ra, rdv}, {10'h0, 6'h02, 16'h0001});

        // Normal read: reg_rd at 3, rvalid sampled at 5, oe released at 6 -> drop at 9
        do_read(6'h00, 16'h00AA, 6, 4, 14, rd_cnt, at, ra, rise, fall, rdv, errs);
        check("rd_count", 32'(rd_cnt), 32'd1);
        check("rd_latency", 32'(at), 32'd3);
        check("rd_addr", 32'(ra), 32'h00);
        check("rd_oe_rise", 32'(rise), 32'd5);
        check("rd_data", 32'(rdv), 32'h00AA);
        check("rd_oe_fall", 32'(fall), 32'd9);
        check("rd_no_err", 32'(errs), 32'd0);

        // Read aborted by the MCU before rvalid; a late rvalid must be ignored
        do_read(6'h2A, 16'h5555, 4, 9, 16, rd_cnt, at, ra, rise, fall, rdv, errs);
        check("abort_rd_count", 32'(rd_cnt), 32'd1);
        check("abort_no_drive", 32'(rise), 32'd0);
        check("abort_no_err", 32'(errs), 32'd0);

        // Read timeout: 8 cycles in RD_WAIT (edges 4..11) then TIMEOUT_DATA
        do_reset();
        do_read(6'h3F, 16'h0000, 20, 0, 28, rd_cnt, at, ra, rise, fall, rdv, errs);
        check("tmo_oe_rise", 32'(rise), 32'd11);
        check("tmo_data", 32'(rdv), 32'hDEAD);
        check("tmo_err_pulses", 32'(errs), 32'd1);
        check("tmo_err_count", 32'(err_count), 32'd1);
        check("tmo_oe_fall", 32'(fall), 32'd23);

        // Strobe falling while chip deselected
        do_reset();
        do_write(6'h11, 16'h1234, 1'b0, 4, 6, 12, cnt, at, ra, rdv, errs, oe_any);
        check("nce_no_wr", 32'(cnt), 32'd0);
        check("nce_err", 32'(errs), 32'd1);
        check("nce_err_count", 32'(err_count), 32'd1);

        // Both strobes, then saturation of err_count
        do_reset();
        do_both(6, 6, errs, acc);
        check("both_no_access", 32'(acc), 32'd0);
        check("both_err", 32'(errs), 32'd1);
        check("both_err_count", 32'(err_count), 32'd1);
        for (int k = 1; k < 254; k++) do_both(4, 4, errs, acc);
        check("sat_fe", 32'(err_count), 32'hFE);
        for (int k = 254; k < 300; k++) do_both(4, 4, errs, acc);
        check("sat_ff", 32'(err_count), 32'hFF);
        check("sat_err_still_pulses", 32'(errs), 32'd1);

        // Reset while driving the bus
        do_reset();
        mc_add = 6'h07;
        for (int i = 0; i < 4; i++) step();
        mc_ce = 1'b0; mc_oe = 1'b0;
        rise = 0;
        for (int i = 1; i <= 12 && rise == 0; i++) begin
            step();
            if (mc_data_oe) rise = i;
            reg_rvalid = (i == 4);
            reg_rdata  = 16'hBEEF;
        end
        reg_rvalid = 1'b0;
        check("mid_drive_reached", 32'(rise), 32'd5);
        reset = 1'b1; mc_oe = 1'b1; mc_ce = 1'b1;
        step();
        check("mid_rst_oe", 32'(mc_data_oe), 32'h0);
        check("mid_rst_data", 32'(mc_data_out), 32'h0);
        reset = 1'b0;
        do_read(6'h05, 16'h1234, 6, 4, 14, rd_cnt, at, ra, rise, fall, rdv, errs);
        check("post_rst_rd_count", 32'(rd_cnt), 32'd1);
        check("post_rst_addr", 32'(ra), 32'h05);
        check("post_rst_data", 32'(rdv), 32'h1234);
        check("post_rst_rise", 32'(rise), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
